eth_speed_detect: RTL and testbench
===================================

// Module: eth_speed_detect
// PURPOSE
//  Parametrised PHY link-speed detector for tri-speed GMII/MII MAC wrappers; replaces inline detect logic.
//  Measures edge rate of a divided PHY RX clock bit against clk over repeated windows.
//  Classifies each window as 10M/100M/1000M; commits only after MATCH_COUNT equal results.
//  Adds valid/change status, register force override and optional link-loss detect.
// PARAMETERS
//  REF_WIDTH    7   reference window counter width; window ends at 2**REF_WIDTH-1 clk cycles
//  EDGE_WIDTH   2   edge counter width; window ends at 2**EDGE_WIDTH-1 edges
//  THRESH_100M  32  ref count at edge-saturation >= this -> 100M, else 1000M
//  MATCH_COUNT  2   consecutive identical window results required to commit (1..15)
//  LOSS_WINDOWS 4   consecutive zero-edge windows before link_lost (macro only)
// PORTS
//  clk              in  1  reference clock (gtx_clk domain)
//  rst              in  1  synchronous active-high reset
//  rx_prescale_bit  in  1  MSB of free-running divider in PHY RX clock domain; async, sampled here
//  cfg_force_en     in  1  1: outputs follow cfg_force_speed
//  cfg_force_speed  in  2  forced speed; 2'b11 treated as 2'b10
//  speed            out 2  00=10M 01=100M 10=1000M
//  mii_select       out 1  1 when speed is 10M or 100M
//  speed_valid      out 1  a measured speed has been committed (or force active)
//  speed_change     out 1  one-cycle pulse when speed output changes value
//  link_lost        out 1  no RX clock edges detected (tied 0 without macro)
// BEHAVIOUR
//  Interface: one clock clk; rst synchronous, active-high.
//  Reset: speed=2'b10, mii_select=0, speed_valid=0, speed_change=0, link_lost=0; counters, candidate, match=0.
//  Input: 3-flop sync chain on rx_prescale_bit; edge = XOR of sync[1]/sync[2] (either polarity counts).
//  ref_cnt increments each cycle; edge_cnt increments per edge, saturating.
//  Window end A: ref_cnt all-ones -> result 10M. Window end B: edge_cnt all-ones ->
//   result 100M if ref_cnt>=THRESH_100M else 1000M. A and B same cycle: B wins.
//  Window end clears both counters in the same cycle (edge that cycle discarded).
//  Match: result==candidate -> match_cnt++ (sat); else candidate<=result, match_cnt<=1.
//  Commit when match_cnt reaches MATCH_COUNT; speed/mii_select update next cycle;
//   speed_valid<=1; speed_change=1 that cycle only if value differs. MATCH_COUNT=1: commit every window.
//  Force: cfg_force_en=1 -> speed=cfg_force_speed one cycle later, speed_valid=1; measurement continues.
//   Deassert -> reverts to last committed value (speed_valid=0 if none); both transitions pulse speed_change if value differs.
//  rst mid-window: all state cleared, next window starts cycle after rst deasserts.
// CONFIGURATION
//  ETH_SPEED_DETECT_LINK_LOSS_EN defined: window end A with edge_cnt==0 increments loss_cnt;
//   at LOSS_WINDOWS -> link_lost=1, speed_valid=0, speed held, zero-edge windows not fed to match logic.
//   First window end B clears loss_cnt, link_lost=0; normal matching resumes (fresh candidate).
//  Undefined: link_lost constant 0; zero-edge windows classify as 10M like any window end A.
// STRUCTURE
//  eth_speed_pkg: SPEED_10M/100M/1000M encoding localparams, speed_t 2-bit typedef.
//  Sub-module eth_speed_meas: sync chain + ref/edge counters, emits result_valid/result.
//  Top: candidate/match, commit, force mux, link-loss, status outputs.
// TESTING (clk 125 MHz, defaults, divider bit = rx_clk/8 toggling every 4 rx cycles)
//  rx_clk 125 MHz -> edge sat at ~12 cycles (<32) -> after 2 windows speed=10, mii_select=0, valid=1, no change pulse.
//  rx_clk 25 MHz -> edge sat at ~60 cycles -> speed=01, mii_select=1, one speed_change pulse.
//  rx_clk 2.5 MHz -> ref overflow at 127 -> speed=00, mii_select=1; switch to 125 MHz -> 1000M after 2 windows.
//  Alternate 25/125 MHz each window -> candidate never matches twice -> speed unchanged, no pulse.
//  cfg_force_en=1, force=2'b11 mid-run -> speed=10 next cycle, valid=1; release -> prior committed value.
//  Macro on, rx clock stopped -> link_lost=1 after 4x127 cycles, valid=0; restart 25 MHz -> link_lost=0, speed=01.

Source files
------------

// File: rtl/eth_speed_pkg.sv
// Shared speed encodings and helpers for the tri-speed link-speed detector.
package eth_speed_pkg;

  typedef logic [1:0] speed_t;

  localparam speed_t SPEED_10M   = 2'b00;
  localparam speed_t SPEED_100M  = 2'b01;
  localparam speed_t SPEED_1000M = 2'b10;

  // The unused encoding 2'b11 is folded onto gigabit.
  function automatic speed_t speed_sanitize(input speed_t s);
    return (s == 2'b11) ? SPEED_1000M : s;
  endfunction

endpackage

// File: rtl/eth_speed_detect_if.sv
// Config/status bundle between the speed detector and its MAC wrapper.
interface eth_speed_detect_if;
  import eth_speed_pkg::*;

  logic   cfg_force_en;
  speed_t cfg_force_speed;
  speed_t speed;
  logic   mii_select;
  logic   speed_valid;
  logic   speed_change;
  logic   link_lost;

  modport master (
    input  cfg_force_en, cfg_force_speed,
    output speed, mii_select, speed_valid, speed_change, link_lost
  );

  modport slave (
    output cfg_force_en, cfg_force_speed,
    input  speed, mii_select, speed_valid, speed_change, link_lost
  );

endinterface

// File: rtl/eth_speed_meas.sv
// Synchronises the divided RX clock bit and classifies each measurement window.
module eth_speed_meas
  import eth_speed_pkg::*;
#(
  parameter int REF_WIDTH   = 7,
  parameter int EDGE_WIDTH  = 2,
  parameter int THRESH_100M = 32
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   rx_prescale_bit_i,
  output logic   result_valid_o,
  output speed_t result_o,
  output logic   zero_edge_o
);

  logic [2:0]            sync_q;
  logic [REF_WIDTH-1:0]  ref_cnt_q;
  logic [EDGE_WIDTH-1:0] edge_cnt_q;
  logic                  edge_det, end_a, end_b;

  // Either polarity of the divider bit counts as an edge.
  assign edge_det = sync_q[1] ^ sync_q[2];
  assign end_a    = &ref_cnt_q;
  assign end_b    = &edge_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      ref_cnt_q  <= '0;
      edge_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], rx_prescale_bit_i};
      if (end_a || end_b) begin
        // An edge landing on the window-end cycle is dropped with the clear.
        ref_cnt_q  <= '0;
        edge_cnt_q <= '0;
      end else begin
        ref_cnt_q <= ref_cnt_q + 1'b1;
        if (edge_det && !end_b) edge_cnt_q <= edge_cnt_q + 1'b1;
      end
    end
  end

  // Edge saturation takes priority when both window ends coincide.
  always_comb begin
    result_valid_o = end_a || end_b;
    result_o       = SPEED_10M;
    if (end_b)
      result_o = (ref_cnt_q >= REF_WIDTH'(THRESH_100M)) ? SPEED_100M : SPEED_1000M;
    zero_edge_o = end_a && (edge_cnt_q == '0);
  end

endmodule

// File: rtl/eth_speed_detect.sv
// Tri-speed PHY link-speed detector: debounced commit, force override, status.
// Optional link-loss detection enabled by defining ETH_SPEED_DETECT_LINK_LOSS_EN.
module eth_speed_detect
  import eth_speed_pkg::*;
#(
  parameter int REF_WIDTH    = 7,
  parameter int EDGE_WIDTH   = 2,
  parameter int THRESH_100M  = 32,
  parameter int MATCH_COUNT  = 2,
  parameter int LOSS_WINDOWS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_prescale_bit,
  eth_speed_detect_if.master sif
);

  logic   res_valid, zero_edge;
  speed_t res_speed;

  eth_speed_meas #(
    .REF_WIDTH  (REF_WIDTH),
    .EDGE_WIDTH (EDGE_WIDTH),
    .THRESH_100M(THRESH_100M)
  ) u_meas (
    .clk              (clk),
    .rst              (rst),
    .rx_prescale_bit_i(rx_prescale_bit),
    .result_valid_o   (res_valid),
    .result_o         (res_speed),
    .zero_edge_o      (zero_edge)
  );

  speed_t     cand_q, cand_d, comm_spd_q, comm_spd_d, speed_q, speed_d;
  logic [3:0] match_q, match_d;
  logic       comm_vld_q, comm_vld_d, lost_q, lost_d;
  logic       mii_q, valid_q, change_q;
  logic       feed, fresh;

`ifdef ETH_SPEED_DETECT_LINK_LOSS_EN
  localparam int LOSS_CW = $clog2(LOSS_WINDOWS + 1);
  logic [LOSS_CW-1:0] loss_q, loss_d;
`else
  logic unused_loss;
  assign unused_loss = zero_edge ^ LOSS_WINDOWS[0];
`endif

  always_comb begin
    cand_d     = cand_q;
    match_d    = match_q;
    comm_spd_d = comm_spd_q;
    comm_vld_d = comm_vld_q;
    lost_d     = lost_q;
    feed       = res_valid;
    fresh      = 1'b0;
`ifdef ETH_SPEED_DETECT_LINK_LOSS_EN
    loss_d = loss_q;
    if (res_valid) begin
      if (zero_edge) begin
        // Silent windows only count toward loss; they never vote on speed.
        feed = 1'b0;
        if (loss_q != LOSS_CW'(LOSS_WINDOWS)) loss_d = loss_q + 1'b1;
        if (loss_d == LOSS_CW'(LOSS_WINDOWS)) begin
          lost_d     = 1'b1;
          comm_vld_d = 1'b0;
        end
      end else begin
        loss_d = '0;
        if (res_speed != SPEED_10M) begin
          fresh  = lost_q;
          lost_d = 1'b0;
        end else if (lost_q) begin
          feed = 1'b0;
        end
      end
    end
`endif
    if (feed) begin
      if (!fresh && res_speed == cand_q) begin
        match_d = (match_q == 4'hF) ? match_q : match_q + 1'b1;
      end else begin
        cand_d  = res_speed;
        match_d = 4'd1;
      end
      if (match_d >= 4'(MATCH_COUNT)) begin
        comm_spd_d = res_speed;
        comm_vld_d = 1'b1;
      end
    end
    speed_d = sif.cfg_force_en ? speed_sanitize(sif.cfg_force_speed) : comm_spd_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q     <= SPEED_10M;
      match_q    <= '0;
      comm_spd_q <= SPEED_1000M;
      comm_vld_q <= 1'b0;
      lost_q     <= 1'b0;
      speed_q    <= SPEED_1000M;
      mii_q      <= 1'b0;
      valid_q    <= 1'b0;
      change_q   <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      match_q    <= match_d;
      comm_spd_q <= comm_spd_d;
      comm_vld_q <= comm_vld_d;
      lost_q     <= lost_d;
      speed_q    <= speed_d;
      mii_q      <= (speed_d != SPEED_1000M);
      valid_q    <= sif.cfg_force_en || comm_vld_d;
      change_q   <= (speed_d != speed_q);
    end
  end

`ifdef ETH_SPEED_DETECT_LINK_LOSS_EN
  always_ff @(posedge clk) begin
    if (rst) loss_q <= '0;
    else     loss_q <= loss_d;
  end
  assign sif.link_lost = lost_q;
`else
  assign sif.link_lost = 1'b0;
`endif

  assign sif.speed        = speed_q;
  assign sif.mii_select   = mii_q;
  assign sif.speed_valid  = valid_q;
  assign sif.speed_change = change_q;

endmodule

// File: tb/tb_eth_speed_detect.sv
// Directed bench for eth_speed_detect: free-running divider rates plus hand-placed edge bursts.
`timescale 1ns/1ps
module tb_eth_speed_detect;
  import eth_speed_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic free_bit = 1'b0;
  logic man_bit = 1'b0;
  logic rx_bit;
  int   tog_ns = 32;
  int   acc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   chg_cnt = 0;
  int   base = 0;

  eth_speed_detect_if sif();

  eth_speed_detect dut (
    .clk            (clk),
    .rst            (rst),
    .rx_prescale_bit(rx_bit),
    .sif            (sif)
  );

  assign rx_bit = free_bit ^ man_bit;

  always #4 clk = ~clk;

  // Divider bit: toggles every tog_ns (4 rx clocks); tog_ns==0 stops it.
  initial begin
    #2;
    forever begin
      #4;
      if (tog_ns != 0) begin
        acc += 4;
        if (acc >= tog_ns) begin
          acc = 0;
          free_bit = ~free_bit;
        end
      end else begin
        acc = 0;
      end
    end
  end

  always @(negedge clk) if (!rst && sif.speed_change) chg_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Three edges spaced s cycles after a g-cycle gap, then a 6-cycle tail.
  task automatic burst(input int g, input int s);
    cyc(g);
    man_bit = ~man_bit;
    cyc(s);
    man_bit = ~man_bit;
    cyc(s);
    man_bit = ~man_bit;
    cyc(6);
  endtask

  initial begin
    sif.cfg_force_en    = 1'b0;
    sif.cfg_force_speed = 2'b00;
    cyc(10);
    chk("rst_speed",  32'(sif.speed), 32'h2);
    chk("rst_mii",    32'(sif.mii_select), 32'h0);
    chk("rst_valid",  32'(sif.speed_valid), 32'h0);
    chk("rst_change", 32'(sif.speed_change), 32'h0);
    chk("rst_lost",   32'(sif.link_lost), 32'h0);
    rst = 1'b0;
    base = chg_cnt;

    cyc(200);
    chk("g125_speed", 32'(sif.speed), 32'h2);
    chk("g125_mii",   32'(sif.mii_select), 32'h0);
    chk("g125_valid", 32'(sif.speed_valid), 32'h1);
    chk("g125_pulse", 32'(chg_cnt - base), 32'h0);

    base = chg_cnt;
    tog_ns = 160;
    cyc(400);
    chk("m25_speed", 32'(sif.speed), 32'h1);
    chk("m25_mii",   32'(sif.mii_select), 32'h1);
    chk("m25_valid", 32'(sif.speed_valid), 32'h1);
    chk("m25_pulse", 32'(chg_cnt - base), 32'h1);

    sif.cfg_force_en    = 1'b1;
    sif.cfg_force_speed = 2'b11;
    cyc(1);
    chk("force_speed",  32'(sif.speed), 32'h2);
    chk("force_valid",  32'(sif.speed_valid), 32'h1);
    chk("force_change", 32'(sif.speed_change), 32'h1);
    chk("force_mii",    32'(sif.mii_select), 32'h0);
    cyc(20);
    chk("force_hold", 32'(sif.speed), 32'h2);
    sif.cfg_force_en = 1'b0;
    cyc(1);
    chk("rel_speed",  32'(sif.speed), 32'h1);
    chk("rel_change", 32'(sif.speed_change), 32'h1);
    chk("rel_valid",  32'(sif.speed_valid), 32'h1);
    cyc(1);
    chk("rel_pulse_end", 32'(sif.speed_change), 32'h0);

    base = chg_cnt;
    tog_ns = 1600;
    cyc(900);
    chk("m10_speed", 32'(sif.speed), 32'h0);
    chk("m10_mii",   32'(sif.mii_select), 32'h1);
    chk("m10_pulse", 32'(chg_cnt - base), 32'h1);

    base = chg_cnt;
    tog_ns = 32;
    cyc(200);
    chk("back_speed", 32'(sif.speed), 32'h2);
    chk("back_mii",   32'(sif.mii_select), 32'h0);
    chk("back_pulse", 32'(chg_cnt - base), 32'h1);

    // Burst-driven windows from a clean reset so window boundaries are known.
    tog_ns = 0;
    man_bit = free_bit;
    cyc(5);
    rst = 1'b1;
    cyc(5);
    rst = 1'b0;
    base = chg_cnt;
    for (int i = 0; i < 4; i++) begin
      burst(30, 10);
      burst(0, 3);
    end
    burst(30, 10);
    chk("alt_speed", 32'(sif.speed), 32'h2);
    chk("alt_valid", 32'(sif.speed_valid), 32'h0);
    chk("alt_pulse", 32'(chg_cnt - base), 32'h0);
    for (int i = 0; i < 3; i++) burst(0, 3);
    chk("fast_speed", 32'(sif.speed), 32'h2);
    chk("fast_valid", 32'(sif.speed_valid), 32'h1);
    chk("fast_mii",   32'(sif.mii_select), 32'h0);
    chk("fast_pulse", 32'(chg_cnt - base), 32'h0);

    base = chg_cnt;
    cyc(600);
`ifdef ETH_SPEED_DETECT_LINK_LOSS_EN
    chk("stop_lost",  32'(sif.link_lost), 32'h1);
    chk("stop_valid", 32'(sif.speed_valid), 32'h0);
    chk("stop_speed", 32'(sif.speed), 32'h2);
    chk("stop_pulse", 32'(chg_cnt - base), 32'h0);
`else
    chk("stop_lost",  32'(sif.link_lost), 32'h0);
    chk("stop_valid", 32'(sif.speed_valid), 32'h1);
    chk("stop_speed", 32'(sif.speed), 32'h0);
    chk("stop_pulse", 32'(chg_cnt - base), 32'h1);
`endif

    tog_ns = 160;
    cyc(500);
    chk("restart_lost",  32'(sif.link_lost), 32'h0);
    chk("restart_speed", 32'(sif.speed), 32'h1);
    chk("restart_valid", 32'(sif.speed_valid), 32'h1);
    chk("restart_mii",   32'(sif.mii_select), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
